// File: rtl/antilog2_pkg.sv
// Shared types, default widths and helpers for the base-2 antilogarithm unit.
package antilog2_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned FRAC_W_DEF = 8;
  localparam int unsigned INT_W_DEF  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Mitchell approximation: 2^f ~= 1 + f, i.e. prepend the implicit leading one.
  function automatic logic [FRAC_W_DEF:0] mitchell_mant(input logic [FRAC_W_DEF-1:0] frac);
    return {1'b1, frac};
  endfunction

endpackage

// File: rtl/antilog2_shreg.sv
// Loadable left-shift accumulator with a down-counter and a registered zero flag.
module antilog2_shreg #(
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned MANT_W = 9,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned OUT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [MANT_W-1:0] mant_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic [OUT_W-1:0]  win_o,
  output logic              zero_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  // Next-state: load wins over shift; zero flag tracks cnt==0 one step ahead.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load_i) begin
      acc_d  = ACC_W'(mant_i);
      cnt_d  = cnt_i;
      zero_d = (cnt_i == '0);
    end else if (shift_i) begin
      acc_d  = acc_q << 1;
      cnt_d  = cnt_q - CNT_W'(1);
      zero_d = (cnt_q == CNT_W'(1));
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign win_o  = acc_q[ACC_W-1 -: OUT_W];
  assign zero_o = zero_q;

endmodule

// File: rtl/antilog2.sv
// Iterative 2^x: Mitchell mantissa, then one left shift per clock for the integer part.
module antilog2
  import antilog2_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  parameter int unsigned INT_W  = INT_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [INT_W+FRAC_W-1:0] log_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_W-1:0]       y_o
);

  localparam int unsigned ACC_W = DATA_W + FRAC_W;
  localparam int unsigned LOG_W = INT_W + FRAC_W;

  if (INT_W != $clog2(DATA_W)) begin : g_bad_int_w
    $error("antilog2: INT_W must equal clog2(DATA_W)");
  end

  logic [INT_W-1:0]  int_part;
  logic [FRAC_W-1:0] frac_part;
  logic [FRAC_W:0]   mant;

  assign int_part  = log_i[LOG_W-1 -: INT_W];
  assign frac_part = log_i[FRAC_W-1:0];

  if (FRAC_W == FRAC_W_DEF) begin : g_mant_pkg
    assign mant = mitchell_mant(frac_part);
  end else begin : g_mant_gen
    assign mant = {1'b1, frac_part};
  end

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              load, shift;
  logic [DATA_W-1:0] win;
  logic              cnt_zero;

  antilog2_shreg #(
    .ACC_W  (ACC_W),
    .MANT_W (FRAC_W + 1),
    .CNT_W  (INT_W),
    .OUT_W  (DATA_W)
  ) u_shreg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .shift_i (shift),
    .mant_i  (mant),
    .cnt_i   (int_part),
    .win_o   (win),
    .zero_o  (cnt_zero)
  );

  // Next-state and output logic; done is a single-cycle pulse by default.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          y_d     = win;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_o    = y_q;

endmodule
